i2c_slave_regfile: RTL and testbench

//   I2C target (slave) answering the I2C master: 7-bit addressing, register-pointer write/read.

---
 rtl/i2c_slave_regfile.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target with a small register file. SCL/SDA are oversampled on clk,
// SDA is driven open-drain (o_sda_oe=1 pulls low). A write transaction sets
// the register pointer and then stores bytes with auto-increment. A read
// transaction returns bytes from the pointer, also with auto-increment.
module i2c_slave_regfile #(
    parameter logic [6:0] DEVICE_ADDR = 7'h50,
    parameter int         REG_NUM     = 16,
    parameter logic [7:0] RST_VAL     = 8'h00,
    localparam int        AW          = $clog2(REG_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_scl,
    input  logic          i_sda,
    output logic          o_sda_oe,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic          o_busy,
    output logic          o_stop_flag
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV_ADDR  = 4'd1,
        DEV_ACK   = 4'd2,
        REG_ADDR  = 4'd3,
        REG_ACK   = 4'd4,
        WR_DATA   = 4'd5,
        WR_ACK    = 4'd6,
        RD_DATA   = 4'd7,
        RD_ACK    = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    state_t        state;
    logic          scl_s1, scl_s2, scl_d;
    logic          sda_s1, sda_s2, sda_d;
    logic [2:0]    bit_cnt;
    logic [6:0]    shreg;     // previous 7 received bits, or remaining bits to send
    logic [AW-1:0] ptr;
    logic          rw;        // R/W bit of the matched address byte
    logic          ack_ph;    // 0: waiting for the fall that starts ACK, 1: ACK being driven
    logic          rd_load;   // next SCL fall loads a new read byte
    logic [7:0]    regs [REG_NUM];

    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]    shift_in;

    // Two-stage synchronizer plus one delay stage for edge detection; idle bus is high
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= i_scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= i_sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign shift_in  = {shreg, sda_s2};

    // Protocol FSM, register file and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 7'd0;
            ptr         <= '0;
            rw          <= 1'b0;
            ack_ph      <= 1'b0;
            rd_load     <= 1'b0;
            o_sda_oe    <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= 8'd0;
            o_busy      <= 1'b0;
            o_stop_flag <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            o_wr_en     <= 1'b0;
            o_stop_flag <= 1'b0;
            if (stop_det) begin
                // STOP wins over everything and ends any transaction
                state       <= IDLE;
                o_sda_oe    <= 1'b0;
                o_busy      <= 1'b0;
                o_stop_flag <= o_busy;
                bit_cnt     <= 3'd0;
                ack_ph      <= 1'b0;
                rd_load     <= 1'b0;
            end else if (start_det) begin
                // START or repeated START: restart address phase, keep pointer
                state    <= DEV_ADDR;
                o_sda_oe <= 1'b0;
                bit_cnt  <= 3'd0;
                ack_ph   <= 1'b0;
                rd_load  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    DEV_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= shift_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift_in[7:1] == DEVICE_ADDR) begin
                                    state  <= DEV_ACK;
                                    rw     <= shift_in[0];
                                    o_busy <= 1'b1;
                                    ack_ph <= 1'b0;
                                end else begin
                                    state  <= WAIT_STOP;
                                    o_busy <= 1'b0;
                                end
                            end
                        end
                    end
                    DEV_ACK, REG_ACK, WR_ACK: begin
                        // ACK is held low from the fall after the 8th bit to the fall after the 9th
                        if (scl_fall) begin
                            if (!ack_ph) begin
                                o_sda_oe <= 1'b1;
                                ack_ph   <= 1'b1;
                            end else begin
                                ack_ph   <= 1'b0;
                                bit_cnt  <= 3'd0;
                                o_sda_oe <= 1'b0;
                                if (state == DEV_ACK && rw) begin
                                    // first read byte: MSB goes out on this same fall
                                    state    <= RD_DATA;
                                    shreg    <= regs[ptr][6:0];
                                    o_sda_oe <= ~regs[ptr][7];
                                end else if (state == DEV_ACK) begin
                                    state <= REG_ADDR;
                                end else begin
                                    state <= WR_DATA;
                                end
                            end
                        end
                    end
                    REG_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= shift_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr    <= shift_in[AW-1:0];
                                state  <= REG_ACK;
                                ack_ph <= 1'b0;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= shift_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                regs[ptr] <= shift_in;
                                o_wr_en   <= 1'b1;
                                o_wr_addr <= ptr;
                                o_wr_data <= shift_in;
                                ptr       <= ptr + AW'(1);
                                state     <= WR_ACK;
                                ack_ph    <= 1'b0;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (rd_load) begin
                                rd_load  <= 1'b0;
                                shreg    <= regs[ptr][6:0];
                                o_sda_oe <= ~regs[ptr][7];
                                bit_cnt  <= 3'd0;
                            end else if (bit_cnt == 3'd7) begin
                                o_sda_oe <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                o_sda_oe <= ~shreg[6];
                                shreg    <= {shreg[5:0], 1'b0};
                                bit_cnt  <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s2) begin
                                ptr     <= ptr + AW'(1);
                                rd_load <= 1'b1;
                                state   <= RD_DATA;
                            end else begin
                                state  <= WAIT_STOP;
                                o_busy <= 1'b0;
                            end
                        end
                    end
                    WAIT_STOP: begin
                        o_sda_oe <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        o_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bit-banged I2C master, a transaction-level
// register-file model, a write scoreboard, table vectors and random traffic.
module tb_i2c_slave_regfile;

    localparam int HP      = 10;   // SCL half period in clk cycles
    localparam int REG_NUM = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_scl;
    logic        m_sda;
    logic        sda_bus;
    logic        o_sda_oe;
    logic        o_wr_en;
    logic [3:0]  o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        o_busy;
    logic        o_stop_flag;

    // wired-AND open-drain bus
    assign sda_bus = m_sda & ~o_sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regfile #(
        .DEVICE_ADDR(7'h50),
        .REG_NUM    (REG_NUM),
        .RST_VAL    (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (m_scl),
        .i_sda      (sda_bus),
        .o_sda_oe   (o_sda_oe),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_busy     (o_busy),
        .o_stop_flag(o_stop_flag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    logic [7:0]  tx_q[$];
    int          stop_cnt = 0;
    int          oe_cnt   = 0;

    logic [7:0]  m_regs [REG_NUM];
    int          m_ptr;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
    } wvec_t;

    wvec_t vecs [4];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (o_wr_en) obs_q.push_back({o_wr_addr, o_wr_data});
        if (o_stop_flag) stop_cnt++;
        if (o_sda_oe) oe_cnt++;
    end

    task automatic model_reset();
        for (int i = 0; i < REG_NUM; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (m_scl && m_sda) begin
            clk_wait(HP);
            m_sda = 1'b0;
            clk_wait(HP);
            m_scl = 1'b0;
        end else begin
            clk_wait(3);
            m_sda = 1'b1;
            clk_wait(HP);
            m_scl = 1'b1;
            clk_wait(HP);
            m_sda = 1'b0;
            clk_wait(HP);
            m_scl = 1'b0;
        end
    endtask

    task automatic bus_stop();
        clk_wait(3);
        m_sda = 1'b0;
        clk_wait(HP);
        m_scl = 1'b1;
        clk_wait(HP);
        m_sda = 1'b1;
        clk_wait(HP);
    endtask

    task automatic drive_bit(input logic b);
        clk_wait(3);
        m_sda = b;
        clk_wait(HP);
        m_scl = 1'b1;
        clk_wait(HP);
        m_scl = 1'b0;
    endtask

    task automatic sample_bit(output logic b);
        clk_wait(3);
        m_sda = 1'b1;
        clk_wait(HP);
        m_scl = 1'b1;
        clk_wait(HP / 2);
        b = sda_bus;
        clk_wait(HP / 2);
        m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
        sample_bit(s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sample_bit(s);
            d[i] = s;
        end
        drive_bit(~mack);
    endtask

    task automatic compare_writes(input string tag);
        logic [11:0] e, o;
        check({tag, " wr_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, " wr_addr_data"}, o, e);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Write transaction: tx_q[0] is the register pointer, the rest are data bytes
    task automatic wr_txn(input logic [7:0] dev, input string tag);
        logic a;
        logic match;
        int   stop0, oe0;
        match = (dev[7:1] == 7'h50) && !dev[0];
        stop0 = stop_cnt;
        oe0   = oe_cnt;
        bus_start();
        send_byte(dev, a);
        check({tag, " dev_ack"}, a, match);
        if (match) check({tag, " busy"}, o_busy, 1);
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], a);
            check($sformatf("%s byte%0d_ack", tag, i), a, match);
        end
        bus_stop();
        clk_wait(5);
        if (match) begin
            m_ptr = tx_q[0] % REG_NUM;
            for (int i = 1; i < tx_q.size(); i++) begin
                m_regs[m_ptr] = tx_q[i];
                exp_q.push_back({m_ptr[3:0], tx_q[i]});
                m_ptr = (m_ptr + 1) % REG_NUM;
            end
        end else begin
            check({tag, " oe_cycles"}, oe_cnt - oe0, 0);
        end
        check({tag, " stop_flag"}, stop_cnt - stop0, match ? 1 : 0);
        check({tag, " busy_after"}, o_busy, 0);
        compare_writes(tag);
    endtask

    // Read transaction: optionally set the pointer then repeated START, n bytes, last NACKed
    task automatic rd_txn(input int n, input logic set_ptr, input logic [7:0] p, input string tag);
        logic       a;
        logic [7:0] d;
        int         stop0;
        stop0 = stop_cnt;
        bus_start();
        if (set_ptr) begin
            send_byte(8'hA0, a);
            check({tag, " wdev_ack"}, a, 1);
            send_byte(p, a);
            check({tag, " ptr_ack"}, a, 1);
            m_ptr = p % REG_NUM;
            bus_start();
        end
        send_byte(8'hA1, a);
        check({tag, " rdev_ack"}, a, 1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k != n - 1, d);
            check($sformatf("%s rd%0d_reg%0d", tag, k, m_ptr), d, m_regs[m_ptr]);
            if (k != n - 1) m_ptr = (m_ptr + 1) % REG_NUM;
        end
        clk_wait(5);
        check({tag, " oe_released"}, o_sda_oe, 0);
        check({tag, " busy_after_nack"}, o_busy, 0);
        bus_stop();
        clk_wait(5);
        check({tag, " no_stop_flag"}, stop_cnt - stop0, 0);
        compare_writes(tag);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic b;
        int   stop0;
        int   r, n;
        logic [7:0] dv;

        vecs[0] = '{dev: 8'hA0, ptr: 8'h03, data: 8'h5A, exp_ack: 1'b1};
        vecs[1] = '{dev: 8'hA2, ptr: 8'h03, data: 8'h77, exp_ack: 1'b0};
        vecs[2] = '{dev: 8'hA0, ptr: 8'h27, data: 8'hC3, exp_ack: 1'b1};
        vecs[3] = '{dev: 8'h20, ptr: 8'h05, data: 8'h99, exp_ack: 1'b0};

        // reset
        rst   = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        model_reset();
        clk_wait(2);
        check("reset oe", o_sda_oe, 0);
        check("reset busy", o_busy, 0);
        check("reset wr_en", o_wr_en, 0);
        check("reset stop_flag", o_stop_flag, 0);
        rst = 1'b0;
        clk_wait(5);
        obs_q.delete();

        // all registers read back as the reset value
        rd_txn(16, 1'b1, 8'h00, "reset_read");

        // single-byte write vectors, including address mismatches
        for (int i = 0; i < 4; i++) begin
            tx_q = '{vecs[i].ptr, vecs[i].data};
            wr_txn(vecs[i].dev, $sformatf("vec%0d", i));
            check($sformatf("vec%0d ack_table", i), (vecs[i].dev[7:1] == 7'h50), vecs[i].exp_ack);
        end

        // burst across the top register: pointer wraps 15 -> 0
        tx_q = '{8'h0F, 8'h11, 8'h22};
        wr_txn(8'hA0, "burst_wrap");
        check("burst reg15", m_regs[15], 8'h11);
        check("burst reg0", m_regs[0], 8'h22);
        rd_txn(2, 1'b1, 8'h0F, "burst_readback");

        // read with repeated START: reg3 then reg4
        rd_txn(2, 1'b1, 8'h03, "rd_sr");
        check("rd_sr reg3", m_regs[3], 8'h5A);

        // abort: STOP four bits into a data byte
        stop0 = stop_cnt;
        bus_start();
        send_byte(8'hA0, a);
        check("abort dev_ack", a, 1);
        send_byte(8'h05, a);
        check("abort ptr_ack", a, 1);
        m_ptr = 5;
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        bus_stop();
        clk_wait(5);
        check("abort busy", o_busy, 0);
        check("abort stop_flag", stop_cnt - stop0, 1);
        compare_writes("abort");

        // reset in the middle of a read that is pulling SDA low
        tx_q = '{8'h08, 8'h00};
        wr_txn(8'hA0, "prep_zero");
        bus_start();
        send_byte(8'hA0, a);
        send_byte(8'h08, a);
        bus_start();
        send_byte(8'hA1, a);
        check("midrst rdev_ack", a, 1);
        for (int i = 0; i < 3; i++) sample_bit(b);
        check("midrst data_bit", b, 0);
        clk_wait(6);
        check("midrst oe_before", o_sda_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst oe_after", o_sda_oe, 0);
        clk_wait(1);
        rst = 1'b0;
        m_sda = 1'b1;
        clk_wait(3);
        m_scl = 1'b1;
        clk_wait(HP);
        model_reset();
        obs_q.delete();
        check("midrst busy", o_busy, 0);
        rd_txn(1, 1'b1, 8'h03, "post_reset");

        // random traffic checked against the model
        for (int t = 0; t < 18; t++) begin
            r = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            if (r <= 1) begin
                dv = 8'hA0;
                if (r == 0 && $urandom_range(0, 3) == 0) begin
                    dv[7:1] = 7'($urandom_range(0, 127));
                    if (dv[7:1] == 7'h50) dv[7:1] = 7'h51;
                end
                tx_q = {};
                tx_q.push_back(8'($urandom_range(0, 255)));
                for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
                wr_txn(dv, $sformatf("rnd%0d_wr", t));
            end else begin
                rd_txn(n, r == 2, 8'($urandom_range(0, 255)), $sformatf("rnd%0d_rd", t));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
